// File: rtl/stack_arbiter_pkg.sv
// Shared definitions for the two-requester stack arbiter: FSM encoding, op codes
// and default geometry.
package stack_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN0    = 2'd1,
        ST_OWN1    = 2'd2,
        ST_POPWAIT = 2'd3
    } state_t;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    localparam int DEF_DEPTH = 1024;
    localparam int DEF_AW    = 10;

    // Last-grant value after reset; pointing at requester 1 makes requester 0 win first.
    localparam logic RR_RESET_LAST = 1'b1;

endpackage

// File: rtl/stack_rr_grant.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to the
// requester that was not granted last.
module stack_rr_grant
    import stack_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    input  logic       i_upd_id,
    output logic [1:0] o_gnt
);

    logic r_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= RR_RESET_LAST;
        end else if (i_upd) begin
            r_last <= i_upd_id;
        end
    end

    always_comb begin
        o_gnt = i_req;
        if (&i_req) begin
            o_gnt = r_last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Arbitrates two requesters onto an external LIFO storage with transfer-level
// grants, optional lock, overflow/underflow protection. Error flags and the
// error pulse are built only when STACK_ARB_ERR_IRQ_EN is defined.
module stack_arbiter
    import stack_arbiter_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          r0_valid,
    input  logic          r0_op,
    input  logic [31:0]   r0_d,
    input  logic          r0_lock,
    output logic          r0_ready,
    output logic          r0_rvalid,
    output logic [31:0]   r0_q,
    input  logic          r1_valid,
    input  logic          r1_op,
    input  logic [31:0]   r1_d,
    input  logic          r1_lock,
    output logic          r1_ready,
    output logic          r1_rvalid,
    output logic [31:0]   r1_q,
    output logic          st_push,
    output logic          st_pop,
    output logic [31:0]   st_d,
    input  logic [31:0]   st_q,
    output logic          st_clr,
    output logic          st_hold,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    input  logic          err_clr,
    output logic          err_ovf,
    output logic          err_unf,
    output logic          err_irq
);

    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

    state_t      r_state;
    logic        r_owner;
    logic        r_unf;
    logic [AW:0] r_count;

    logic [1:0]  w_gnt;
    logic [1:0]  w_acc;
    logic        w_any, w_sel, w_op, w_lock, w_own_lock, w_drop;
    logic        w_push, w_pop, w_full, w_empty, w_ovf_evt, w_unf_evt;
    logic [31:0] w_pop_q;

    stack_rr_grant u_rr (
        .clk      (clk),
        .reset    (reset),
        .i_req    ({r1_valid, r0_valid}),
        .i_upd    (w_any | w_drop),
        .i_upd_id (w_any ? w_sel : r_owner),
        .o_gnt    (w_gnt)
    );

    // Only IDLE arbitrates; an owned state serves its owner alone, POPWAIT serves nobody.
    always_comb begin
        w_acc = 2'b00;
        case (r_state)
            ST_IDLE: w_acc = w_gnt;
            ST_OWN0: w_acc = {1'b0, r0_valid};
            ST_OWN1: w_acc = {r1_valid, 1'b0};
            default: w_acc = 2'b00;
        endcase
    end

    assign w_any      = |w_acc;
    assign w_sel      = w_acc[1];
    assign w_op       = w_sel ? r1_op : r0_op;
    assign w_lock     = w_sel ? r1_lock : r0_lock;
    assign w_own_lock = r_owner ? r1_lock : r0_lock;
    assign w_drop     = ((r_state == ST_OWN0) && !r0_valid && !r0_lock) ||
                        ((r_state == ST_OWN1) && !r1_valid && !r1_lock);

    assign w_full    = (r_count == LP_DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_push    = w_any && (w_op == OP_PUSH);
    assign w_pop     = w_any && (w_op == OP_POP);
    assign w_ovf_evt = w_push && w_full;
    assign w_unf_evt = w_pop && w_empty;

    assign r0_ready = w_acc[0];
    assign r1_ready = w_acc[1];
    assign st_push  = w_push && !w_full;
    assign st_pop   = w_pop && !w_empty;
    assign st_d     = w_sel ? r1_d : r0_d;
    assign st_clr   = 1'b0;
    assign st_hold  = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            case (r_state)
                ST_POPWAIT: r_state <= w_own_lock ? (r_owner ? ST_OWN1 : ST_OWN0) : ST_IDLE;
                default: begin
                    if (w_any) begin
                        r_owner <= w_sel;
                        r_unf   <= w_empty;
                        if (w_op == OP_POP) begin
                            r_state <= ST_POPWAIT;
                        end else begin
                            r_state <= w_lock ? (w_sel ? ST_OWN1 : ST_OWN0) : ST_IDLE;
                        end
                    end else if (w_drop) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (st_push) begin
            r_count <= r_count + (AW+1)'(1);
        end else if (st_pop) begin
            r_count <= r_count - (AW+1)'(1);
        end
    end

    // An underflowed pop returns zero instead of whatever the storage holds.
    assign w_pop_q   = r_unf ? 32'd0 : st_q;
    assign r0_rvalid = (r_state == ST_POPWAIT) && !r_owner;
    assign r1_rvalid = (r_state == ST_POPWAIT) && r_owner;
    assign r0_q      = r0_rvalid ? w_pop_q : 32'd0;
    assign r1_q      = r1_rvalid ? w_pop_q : 32'd0;

    assign count = r_count;
    assign full  = w_full;
    assign empty = w_empty;

`ifdef STACK_ARB_ERR_IRQ_EN
    logic r_err_ovf, r_err_unf, r_err_irq;

    // A new event wins over a simultaneous clear so it is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
            r_err_irq <= 1'b0;
        end else begin
            r_err_irq <= w_ovf_evt | w_unf_evt;
            r_err_ovf <= w_ovf_evt | (r_err_ovf & ~err_clr);
            r_err_unf <= w_unf_evt | (r_err_unf & ~err_clr);
        end
    end

    assign err_ovf = r_err_ovf;
    assign err_unf = r_err_unf;
    assign err_irq = r_err_irq;
`else
    logic w_unused;
    assign w_unused = &{1'b0, err_clr, w_ovf_evt, w_unf_evt};

    assign err_ovf = 1'b0;
    assign err_unf = 1'b0;
    assign err_irq = 1'b0;
`endif

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based transaction model; honours STACK_ARB_ERR_IRQ_EN.
module tb_stack_arbiter;
    import stack_arbiter_pkg::*;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;
`ifdef STACK_ARB_ERR_IRQ_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk, reset;
    logic        r0_valid, r0_op, r0_lock, r1_valid, r1_op, r1_lock;
    logic [31:0] r0_d, r1_d;
    logic        r0_ready, r0_rvalid, r1_ready, r1_rvalid;
    logic [31:0] r0_q, r1_q;
    logic        st_push, st_pop, st_clr, st_hold;
    logic [31:0] st_d, st_q;
    logic [AW:0] count;
    logic        full, empty, err_clr, err_ovf, err_unf, err_irq;

    stack_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_op(r0_op), .r0_d(r0_d), .r0_lock(r0_lock),
        .r0_ready(r0_ready), .r0_rvalid(r0_rvalid), .r0_q(r0_q),
        .r1_valid(r1_valid), .r1_op(r1_op), .r1_d(r1_d), .r1_lock(r1_lock),
        .r1_ready(r1_ready), .r1_rvalid(r1_rvalid), .r1_q(r1_q),
        .st_push(st_push), .st_pop(st_pop), .st_d(st_d), .st_q(st_q),
        .st_clr(st_clr), .st_hold(st_hold),
        .count(count), .full(full), .empty(empty),
        .err_clr(err_clr), .err_ovf(err_ovf), .err_unf(err_unf), .err_irq(err_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External LIFO storage: read data appears one cycle after st_pop.
    logic [31:0] mem [DEPTH];
    int          sp;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sp   <= 0;
            st_q <= 32'd0;
        end else begin
            if (st_push && sp < DEPTH) begin
                mem[sp] <= st_d;
                sp      <= sp + 1;
            end else if (st_pop && sp > 0) begin
                st_q <= mem[sp-1];
                sp   <= sp - 1;
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Transaction-level model: contents as a queue, who holds the lock,
    // which requester waits for pop data, who wins the next tie.
    logic [31:0] m_stack[$];
    int          m_pend, m_lock_to, m_prio;
    logic [31:0] m_pend_q;
    logic        m_ovf, m_unf, m_irq;

    int          obs_win;
    logic        obs_rv0, obs_push;
    logic [31:0] obs_q0;

    task automatic model_reset();
        m_stack.delete();
        m_pend = -1; m_lock_to = -1; m_prio = 0;
        m_pend_q = 32'd0;
        m_ovf = 1'b0; m_unf = 1'b0; m_irq = 1'b0;
    endtask

    task automatic cycle(input logic v0, input logic o0, input logic [31:0] d0, input logic l0,
                         input logic v1, input logic o1, input logic [31:0] d1, input logic l1,
                         input logic clr);
        logic [1:0]  v, o, l, e_rdy, e_rv;
        logic [31:0] d [2];
        logic [31:0] e_q [2];
        logic [31:0] e_d;
        logic        e_push, e_pop, ovf_e, unf_e;
        int          win;
        @(negedge clk);
        r0_valid = v0; r0_op = o0; r0_d = d0; r0_lock = l0;
        r1_valid = v1; r1_op = o1; r1_d = d1; r1_lock = l1;
        err_clr = clr;
        #1;
        check_value("count", 32'(count), 32'(m_stack.size()));
        check_value("full", full, m_stack.size() == DEPTH);
        check_value("empty", empty, m_stack.size() == 0);
        check_value("err_ovf", err_ovf, ERR_EN & m_ovf);
        check_value("err_unf", err_unf, ERR_EN & m_unf);
        check_value("err_irq", err_irq, ERR_EN & m_irq);

        v = {v1, v0}; o = {o1, o0}; l = {l1, l0}; d[0] = d0; d[1] = d1;
        e_rdy = 2'b00; e_rv = 2'b00; e_q[0] = 32'd0; e_q[1] = 32'd0; e_d = 32'd0;
        e_push = 1'b0; e_pop = 1'b0; ovf_e = 1'b0; unf_e = 1'b0; win = -1;
        if (m_pend >= 0) begin
            e_rv[m_pend] = 1'b1;
            e_q[m_pend]  = m_pend_q;
            m_lock_to    = l[m_pend] ? m_pend : -1;
            m_pend       = -1;
        end else begin
            if (m_lock_to >= 0) begin
                if (v[m_lock_to]) win = m_lock_to;
                else if (!l[m_lock_to]) begin
                    m_prio    = 1 - m_lock_to;
                    m_lock_to = -1;
                end
            end else if (v[0] && v[1]) win = m_prio;
            else if (v[0]) win = 0;
            else if (v[1]) win = 1;
            if (win >= 0) begin
                e_rdy[win] = 1'b1;
                m_prio     = 1 - win;
                if (o[win] == OP_PUSH) begin
                    if (m_stack.size() == DEPTH) ovf_e = 1'b1;
                    else begin
                        m_stack.push_back(d[win]);
                        e_push = 1'b1;
                        e_d    = d[win];
                    end
                    m_lock_to = l[win] ? win : -1;
                end else begin
                    m_pend    = win;
                    m_lock_to = -1;
                    if (m_stack.size() == 0) begin
                        unf_e    = 1'b1;
                        m_pend_q = 32'd0;
                    end else begin
                        m_pend_q = m_stack.pop_back();
                        e_pop    = 1'b1;
                    end
                end
            end
        end

        check_value("r0_ready", r0_ready, e_rdy[0]);
        check_value("r1_ready", r1_ready, e_rdy[1]);
        check_value("r0_rvalid", r0_rvalid, e_rv[0]);
        check_value("r1_rvalid", r1_rvalid, e_rv[1]);
        if (e_rv[0]) check_value("r0_q", r0_q, e_q[0]);
        if (e_rv[1]) check_value("r1_q", r1_q, e_q[1]);
        check_value("st_push", st_push, e_push);
        check_value("st_pop", st_pop, e_pop);
        if (e_push) check_value("st_d", st_d, e_d);

        m_irq = ovf_e | unf_e;
        m_ovf = ovf_e | (m_ovf & ~clr);
        m_unf = unf_e | (m_unf & ~clr);

        obs_win  = r0_ready ? 0 : (r1_ready ? 1 : -1);
        obs_rv0  = r0_rvalid;
        obs_q0   = r0_q;
        obs_push = st_push;
        if (win >= 0)
            $display("%0t: r%0d %s d=%08h count=%0d", $time, win,
                     o[win] ? "pop " : "push", d[win], m_stack.size());
        else if (e_rv != 2'b00)
            $display("%0t: r%0d rvalid q=%08h", $time, e_rv[1] ? 1 : 0, e_rv[1] ? r1_q : r0_q);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, OP_PUSH, 0, 0, 0, OP_PUSH, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        r0_valid = 0; r1_valid = 0; r0_lock = 0; r1_lock = 0; err_clr = 0;
        #1;
        check_value("rst_count", 32'(count), 0);
        check_value("rst_empty", empty, 1);
        check_value("rst_full", full, 0);
        check_value("rst_ready", {r1_ready, r0_ready}, 0);
        check_value("rst_rvalid", {r1_rvalid, r0_rvalid}, 0);
        check_value("rst_q", r0_q | r1_q, 0);
        check_value("rst_strobes", {st_push, st_pop, st_clr, st_hold}, 0);
        check_value("rst_flags", {err_ovf, err_unf, err_irq}, 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset = 1'b1;
        r0_valid = 0; r0_op = 0; r0_d = 0; r0_lock = 0;
        r1_valid = 0; r1_op = 0; r1_d = 0; r1_lock = 0;
        err_clr = 0;
        model_reset();

        // Pop from an empty stack
        do_reset();
        cycle(1, OP_POP, 0, 0, 0, OP_PUSH, 0, 0, 0);
        check_value("unf_nostpop", obs_push | st_pop, 0);
        cycle(0, OP_PUSH, 0, 0, 0, OP_PUSH, 0, 0, 0);
        check_value("unf_rvalid", obs_rv0, 1);
        check_value("unf_q", obs_q0, 0);
        check_value("unf_flag", err_unf, ERR_EN);

        // Continuous contention alternates starting with requester 0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1, OP_PUSH, 32'(i), 0, 1, OP_PUSH, 32'(100 + i), 0, 0);
            check_value("rr_order", 32'(obs_win), 32'(i % 2));
        end

        // Push 0x11, 0x22, pop returns 0x22 one cycle after ready
        do_reset();
        cycle(1, OP_PUSH, 32'h11, 0, 0, OP_PUSH, 0, 0, 0);
        cycle(1, OP_PUSH, 32'h22, 0, 0, OP_PUSH, 0, 0, 0);
        cycle(1, OP_POP, 0, 0, 0, OP_PUSH, 0, 0, 0);
        check_value("pop_ready", 32'(obs_win), 0);
        check_value("count_two", 32'(count), 2);
        cycle(0, OP_PUSH, 0, 0, 0, OP_PUSH, 0, 0, 0);
        check_value("pop_rvalid", obs_rv0, 1);
        check_value("pop_q", obs_q0, 32'h22);
        check_value("count_one", 32'(count), 1);

        // Locked requester 1 keeps requester 0 out until lock drops
        cycle(0, OP_PUSH, 0, 0, 1, OP_PUSH, 32'hA0, 1, 0);
        check_value("lock_first", 32'(obs_win), 1);
        for (int k = 0; k < 3; k++) begin
            cycle(1, OP_PUSH, 32'hB0, 0, 1, OP_PUSH, 32'hA1 + 32'(k), 1, 0);
            check_value("lock_hold", 32'(obs_win), 1);
        end
        cycle(1, OP_PUSH, 32'hB0, 0, 0, OP_PUSH, 0, 0, 0);
        check_value("lock_drop", 32'(obs_win), -1);
        cycle(1, OP_PUSH, 32'hB0, 0, 0, OP_PUSH, 0, 0, 0);
        check_value("lock_next", 32'(obs_win), 0);

        // Fill, then overflow
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1, OP_PUSH, 32'(i), 0, 0, OP_PUSH, 0, 0, 0);
        cycle(1, OP_PUSH, 32'hDEAD, 0, 0, OP_PUSH, 0, 0, 0);
        check_value("ovf_ready", 32'(obs_win), 0);
        check_value("ovf_nostpush", obs_push, 0);
        cycle(0, OP_PUSH, 0, 0, 0, OP_PUSH, 0, 0, 0);
        check_value("ovf_count", 32'(count), DEPTH);
        check_value("ovf_flag", err_ovf, ERR_EN);
        check_value("ovf_irq", err_irq, ERR_EN);
        cycle(0, OP_PUSH, 0, 0, 0, OP_PUSH, 0, 0, 1);
        check_value("ovf_irq_once", err_irq, 0);
        cycle(0, OP_PUSH, 0, 0, 0, OP_PUSH, 0, 0, 0);
        check_value("ovf_clr", err_ovf, 0);

        // Reset while a pop is pending
        cycle(1, OP_POP, 0, 0, 0, OP_PUSH, 0, 0, 0);
        @(negedge clk);
        r0_valid = 0;
        #1;
        check_value("pw_rvalid_pre", r0_rvalid, 1);
        reset = 1'b1;
        #1;
        check_value("pw_rvalid_rst", r0_rvalid, 0);
        check_value("pw_count_rst", 32'(count), 0);
        @(posedge clk);
        #1;
        check_value("pw_rvalid_edge", r0_rvalid | r1_rvalid, 0);
        check_value("pw_empty_edge", empty, 1);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        cycle(1, OP_PUSH, 32'h5A, 0, 0, OP_PUSH, 0, 0, 0);
        check_value("pw_idle_after", 32'(obs_win), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 2) != 0, 1'($urandom), $urandom, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 2) != 0, 1'($urandom), $urandom, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 15) == 0);
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 Parameter DEPTH, default 1024, stack entries; SHALL be a power of two.
REQ-002 Parameter AW, default 10, pointer/count width; SHALL equal log2(DEPTH).
REQ-003 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 rN_valid  in  1  request from requester N (N=0 CPU pipeline, N=1 interrupt context-save unit).
REQ-006 rN_op  in  1  0=push, 1=pop.
REQ-007 rN_d  in  32  push data.
REQ-008 rN_lock  in  1  hold grant after the current transfer.
REQ-009 rN_ready  out  1  request accepted this cycle.
REQ-010 rN_rvalid  out  1  pop data valid on rN_q.
REQ-011 rN_q  out  32  pop data.
REQ-012 st_push, st_pop  out  1 each  storage strobes; st_d  out  32; st_q  in  32, valid one cycle after st_pop.
REQ-013 count  out  AW+1  current occupancy; full, empty  out  1 each.
REQ-014 err_clr  in  1  clears sticky error flags.
REQ-015 err_ovf, err_unf  out  1 each  sticky overflow/underflow flags; err_irq  out  1  one-cycle error pulse.

Function
REQ-016 FSM states: IDLE, OWN0, OWN1, POPWAIT.
REQ-017 IDLE: a single valid requester SHALL be granted; if both are valid, grant SHALL go to the requester not granted last (round-robin; after reset requester 0 wins).
REQ-018 Grant SHALL be transfer-level: rN_ready high for exactly one cycle per accepted request; the same cycle SHALL drive st_push or st_pop.
REQ-019 An accepted push SHALL complete in one cycle; next state SHALL be OWNn if rN_lock=1, else IDLE.
REQ-020 An accepted pop SHALL enter POPWAIT; the next cycle SHALL assert rN_rvalid with rN_q=st_q, then go to OWNn if lock, else IDLE.
REQ-021 In OWNn only requester n SHALL be served; dropping rN_lock with no valid request SHALL return to IDLE and hand priority to the other requester.
REQ-022 At most one storage operation SHALL issue per cycle; no request SHALL be accepted in POPWAIT.
REQ-023 count SHALL increment on an accepted non-overflow push and decrement on an accepted non-underflow pop; full=(count==DEPTH), empty=(count==0).
REQ-024 Push while full SHALL be accepted (ready=1), SHALL NOT drive st_push, and SHALL set err_ovf.
REQ-025 Pop while empty SHALL be accepted, SHALL NOT drive st_pop, SHALL return rvalid with rN_q=0 the next cycle, and SHALL set err_unf.
REQ-026 err_irq SHALL pulse for one cycle on each overflow/underflow event; err_clr SHALL clear the flags; a simultaneous event and err_clr SHALL leave the flag set.
REQ-027 The storage clear/hold inputs SHALL be tied low.

Reset
REQ-028 Reset SHALL force IDLE, count=0, empty=1, full=0, all ready/rvalid/strobes/flags/irq to 0, rN_q=0, and round-robin priority to requester 0.
REQ-029 Reset during POPWAIT SHALL drop the pending rvalid; storage contents need not be cleared.

Configuration
REQ-030 Macro STACK_ARB_ERR_IRQ_EN defined: REQ-024 to REQ-026 flags and pulse are active.
REQ-031 Macro undefined: err_ovf, err_unf and err_irq SHALL be constant 0; overflow/underflow protection (no strobe, zero data) SHALL remain.

Structure
REQ-032 Shared package SHALL hold the FSM state encoding, the op codes (OP_PUSH=0, OP_POP=1) and default DEPTH/AW.
REQ-033 Round-robin grant logic SHALL be a sub-module stack_rr_grant (two requesters, last-grant register).
REQ-034 Storage SHALL remain external to this block.

Verification
REQ-035 r0 push 0x11, 0x22, then pop -> pop rvalid one cycle after ready, r0_q=0x22, count 2 then 1.
REQ-036 r0 and r1 both request push continuously -> grants alternate 0,1,0,1 starting with 0.
REQ-037 r1_lock=1, r1 pushes 4 words while r0_valid=1 -> r0_ready stays low until r1_lock drops, then r0 is served next.
REQ-038 Fill to DEPTH, push 0xDEAD -> ready=1, no st_push, count=DEPTH, err_ovf=1, one err_irq pulse; err_clr -> err_ovf=0.
REQ-039 Pop when empty -> rvalid next cycle, q=0, no st_pop, err_unf=1 (0 with STACK_ARB_ERR_IRQ_EN undefined).
REQ-040 Assert reset in POPWAIT -> no rvalid, state IDLE, count=0 on the next edge.
